// File: rtl/matrix_pkg.sv
// Shared types and default sizing for the streaming matrix multiplier.
package matrix_pkg;

  localparam int DEF_MAX_SIZE = 10;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ACC_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

endpackage

// File: rtl/mm_mac.sv
// Registered multiply-accumulate: operands extended to ACC_W per signed_mode,
// product and sum wrap modulo 2^ACC_W. Clear wins over enable.
module mm_mac
  import matrix_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  // Sign- or zero-extend an operand to accumulator width.
  function automatic logic [ACC_W-1:0] extend(input logic [DATA_W-1:0] v, input logic sgn);
    logic signed [DATA_W:0] sv;
    sv = {sgn & v[DATA_W-1], v};
    return ACC_W'(sv);
  endfunction

  logic [ACC_W-1:0] prod_s;
  logic [ACC_W-1:0] acc_r;

  // Product of the two extended operands, truncated to ACC_W.
  always_comb begin
    prod_s = extend(a, signed_mode) * extend(b, signed_mode);
  end

  // Accumulator register: clear, accumulate, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (clr) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (en) begin
      acc_r <= acc_r + prod_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/matrix_mult_stream.sv
// Streaming NxN matrix multiplier: loads A then B row-major, computes each C
// element with N MAC cycles, and streams C row-major with valid/ready.
module matrix_mult_stream
  import matrix_pkg::*;
#(
  parameter int MAX_SIZE = DEF_MAX_SIZE,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MAX_SIZE+1)-1:0] size,
  input  logic                          signed_mode,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int SZ_W  = $clog2(MAX_SIZE+1);
  localparam int DEPTH = MAX_SIZE * MAX_SIZE;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_r;
  logic [SZ_W-1:0]   size_r, row_r, col_r, i_r, j_r, k_r;
  logic              signed_r;
  logic              in_ready_r, out_valid_r, busy_r, done_r, err_r;
  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];

  logic [SZ_W-1:0]   last_s;
  logic              beat_s, out_fire_s, load_last_s, k_last_s, ij_last_s, size_ok_s;
  logic [IDX_W-1:0]  wr_idx_s, rd_a_idx_s, rd_b_idx_s;
  logic              mac_clr_s, mac_en_s;
  logic [ACC_W-1:0]  acc_s;

  // Handshake qualifiers, end-of-range flags and storage addresses.
  always_comb begin
    last_s      = size_r - SZ_W'(1);
    beat_s      = in_valid & in_ready_r;
    out_fire_s  = out_valid_r & out_ready;
    load_last_s = (row_r == last_s) && (col_r == last_s);
    k_last_s    = (k_r == last_s);
    ij_last_s   = (i_r == last_s) && (j_r == last_s);
    size_ok_s   = (size != SZ_W'(0)) && (size <= SZ_W'(MAX_SIZE));
    wr_idx_s    = IDX_W'(row_r) * IDX_W'(MAX_SIZE) + IDX_W'(col_r);
    rd_a_idx_s  = IDX_W'(i_r) * IDX_W'(MAX_SIZE) + IDX_W'(k_r);
    rd_b_idx_s  = IDX_W'(k_r) * IDX_W'(MAX_SIZE) + IDX_W'(j_r);
  end

  // MAC control: clear on entry to COMPUTE and on abort, accumulate in COMPUTE.
  always_comb begin
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    if (abort) begin
      mac_clr_s = 1'b1;
    end else if ((state_r == ST_LOAD_B) && beat_s && load_last_s) begin
      mac_clr_s = 1'b1;
    end else if ((state_r == ST_OUTPUT) && out_fire_s && !ij_last_s) begin
      mac_clr_s = 1'b1;
    end else if (state_r == ST_COMPUTE) begin
      mac_en_s = 1'b1;
    end else begin
      mac_en_s = 1'b0;
    end
  end

  // Operand storage writes; contents survive reset and abort by design.
  always_ff @(posedge clk) begin
    if (!abort && beat_s && (state_r == ST_LOAD_A)) begin
      a_mem[wr_idx_s] <= in_data;
    end
    if (!abort && beat_s && (state_r == ST_LOAD_B)) begin
      b_mem[wr_idx_s] <= in_data;
    end
  end

  mm_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (mac_clr_s),
    .en          (mac_en_s),
    .signed_mode (signed_r),
    .a           (a_mem[rd_a_idx_s]),
    .b           (b_mem[rd_b_idx_s]),
    .acc         (acc_s)
  );

  // Job FSM with counters and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      size_r      <= SZ_W'(0);
      signed_r    <= 1'b0;
      row_r       <= SZ_W'(0);
      col_r       <= SZ_W'(0);
      i_r         <= SZ_W'(0);
      j_r         <= SZ_W'(0);
      k_r         <= SZ_W'(0);
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (abort) begin
        state_r     <= ST_IDLE;
        row_r       <= SZ_W'(0);
        col_r       <= SZ_W'(0);
        i_r         <= SZ_W'(0);
        j_r         <= SZ_W'(0);
        k_r         <= SZ_W'(0);
        in_ready_r  <= 1'b0;
        out_valid_r <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && size_ok_s) begin
              size_r     <= size;
              signed_r   <= signed_mode;
              row_r      <= SZ_W'(0);
              col_r      <= SZ_W'(0);
              in_ready_r <= 1'b1;
              busy_r     <= 1'b1;
              state_r    <= ST_LOAD_A;
            end else if (start) begin
              err_r <= 1'b1;
            end
          end
          ST_LOAD_A, ST_LOAD_B: begin
            if (beat_s) begin
              if (col_r == last_s) begin
                col_r <= SZ_W'(0);
                row_r <= (row_r == last_s) ? SZ_W'(0) : row_r + SZ_W'(1);
              end else begin
                col_r <= col_r + SZ_W'(1);
              end
              if (load_last_s && (state_r == ST_LOAD_A)) begin
                state_r <= ST_LOAD_B;
              end else if (load_last_s) begin
                in_ready_r <= 1'b0;
                i_r        <= SZ_W'(0);
                j_r        <= SZ_W'(0);
                k_r        <= SZ_W'(0);
                state_r    <= ST_COMPUTE;
              end
            end
          end
          ST_COMPUTE: begin
            if (k_last_s) begin
              k_r         <= SZ_W'(0);
              out_valid_r <= 1'b1;
              state_r     <= ST_OUTPUT;
            end else begin
              k_r <= k_r + SZ_W'(1);
            end
          end
          ST_OUTPUT: begin
            if (out_fire_s) begin
              out_valid_r <= 1'b0;
              if (ij_last_s) begin
                i_r     <= SZ_W'(0);
                j_r     <= SZ_W'(0);
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                state_r <= ST_IDLE;
              end else begin
                if (j_r == last_s) begin
                  j_r <= SZ_W'(0);
                  i_r <= i_r + SZ_W'(1);
                end else begin
                  j_r <= j_r + SZ_W'(1);
                end
                state_r <= ST_COMPUTE;
              end
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = acc_s;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Self-checking bench for matrix_mult_stream: table-driven jobs checked against
// a plain-arithmetic matrix product, plus reset/abort/error sequences.
module tb_matrix_mult_stream;

  logic        clk = 1'b0;
  logic        rst_n, start, signed_mode, abort, in_valid, out_ready;
  logic [3:0]  size;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy, done, err;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_m [100];
  logic [31:0] b_m [100];
  logic [31:0] c_m [100];

  typedef struct {
    int          n;
    bit          sgn;
    int          pat;
    int          stall;
    bit          rnd;
    bit          has_exp;
    logic [31:0] exp00;
  } vec_t;

  vec_t tbl [7];

  matrix_mult_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .signed_mode(signed_mode),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_status"}, {27'd0, busy, in_ready, out_valid, done, err}, 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
  endtask

  function automatic longint ext(input logic [31:0] v, input bit sgn);
    return sgn ? longint'($signed(v)) : longint'(v);
  endfunction

  // Fill operands in stream order and compute the reference product.
  task automatic build(input int n, input bit sgn, input int pat);
    longint s;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        case (pat)
          1: begin a_m[i*n+j] = 32'(10*i + j + 1); b_m[i*n+j] = 32'(100 - 10*j - i); end
          2: begin a_m[i*n+j] = 32'hFFFF_FFFE; b_m[i*n+j] = 32'd3; end
          default: begin a_m[i*n+j] = $urandom; b_m[i*n+j] = $urandom; end
        endcase
      end
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s = s + ext(a_m[i*n+k], sgn) * ext(b_m[k*n+j], sgn);
        c_m[i*n+j] = s[31:0];
      end
    end
  endtask

  task automatic run_job(input int n, input bit sgn, input int pat, input int stall,
                         input bit rnd, input bit has_exp, input logic [31:0] exp00);
    int ptr, oidx, cyc, last_beat, first_valid, stall_left;
    bit fin, err_seen;
    logic [31:0] held;
    build(n, sgn, pat);
    @(negedge clk);
    start = 1'b1; size = 4'(n); signed_mode = sgn;
    @(negedge clk);
    start = 1'b0; size = 4'd0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("in_ready_load", 32'(in_ready), 32'd1);
    ptr = 0; oidx = 0; cyc = 0; last_beat = -1; first_valid = -1; stall_left = 0;
    fin = 1'b0; err_seen = 1'b0; held = 32'd0;
    while (!fin && cyc < 6000) begin
      if (err) err_seen = 1'b1;
      if (done) begin
        fin = 1'b1;
        chk("busy_low_with_done", 32'(busy), 32'd0);
      end
      if (out_valid && first_valid < 0) begin
        first_valid = cyc; stall_left = stall; held = out_data;
      end
      in_valid = (ptr < 2*n*n) && (!rnd || $urandom_range(0, 3) != 0);
      in_data  = !in_valid ? $urandom : (ptr < n*n) ? a_m[ptr] : b_m[ptr-n*n];
      if (in_valid && in_ready) begin
        ptr++;
        if (ptr == 2*n*n) last_beat = cyc;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, held);
        stall_left--;
      end else begin
        out_ready = !rnd || $urandom_range(0, 2) != 0;
      end
      if (out_valid && out_ready) begin
        if (oidx == 0 && has_exp) chk("c00_const", out_data, exp00);
        if (oidx < n*n) chk($sformatf("c[%0d] n=%0d", oidx, n), out_data, c_m[oidx]);
        else chk("extra_output", 32'd1, 32'd0);
        oidx++;
      end
      start = rnd && busy && ($urandom_range(0, 1) == 1);
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (!fin) chk("job_timeout", 32'd0, 32'd1);
    chk("out_count", 32'(oidx), 32'(n*n));
    chk("in_count", 32'(ptr), 32'(2*n*n));
    chk("compute_latency", 32'(first_valid - last_beat), 32'(n + 1));
    chk("no_err_busy_start", 32'(err_seen), 32'd0);
    @(negedge clk);
    chk("done_single_pulse", {29'd0, done, busy, in_ready}, 32'd0);
  endtask

  // Start an N=2 job and push five beats so the FSM sits in LOAD_B.
  task automatic partial_load();
    @(negedge clk);
    start = 1'b1; size = 4'd2; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      in_data = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mid_load_b_ready", {30'd0, busy, in_ready}, 32'd3);
  endtask

  initial begin
    int bad [3];
    int w;
    bad = '{0, 11, 15};
    tbl[0] = '{10, 1'b0, 1, 0, 1'b0, 1'b1, 32'd5170};
    tbl[1] = '{1, 1'b1, 2, 0, 1'b0, 1'b1, 32'hFFFF_FFFA};
    tbl[2] = '{2, 1'b0, 0, 5, 1'b0, 1'b0, 32'd0};
    tbl[3] = '{3, 1'b1, 0, 0, 1'b1, 1'b0, 32'd0};
    tbl[4] = '{5, 1'b0, 0, 2, 1'b1, 1'b0, 32'd0};
    tbl[5] = '{1, 1'b0, 0, 0, 1'b1, 1'b0, 32'd0};
    tbl[6] = '{4, 1'b1, 0, 0, 1'b0, 1'b0, 32'd0};

    rst_n = 1'b0; start = 1'b0; size = 4'd0; signed_mode = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    #1;
    chk_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // Rejected sizes: one err pulse each, nothing else moves.
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      start = 1'b1; size = 4'(bad[e]);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("err_pulse size=%0d", bad[e]), {29'd0, err, busy, in_ready}, 32'd4);
      @(negedge clk);
      chk($sformatf("err_clear size=%0d", bad[e]), {29'd0, err, busy, in_ready}, 32'd0);
    end

    for (int t = 0; t < 7; t++) begin
      run_job(tbl[t].n, tbl[t].sgn, tbl[t].pat, tbl[t].stall, tbl[t].rnd,
              tbl[t].has_exp, tbl[t].exp00);
    end

    // Reset during LOAD_B, then a clean job.
    partial_load();
    rst_n = 1'b0;
    #1;
    chk_idle("reset_mid_job");
    @(negedge clk);
    rst_n = 1'b1;
    run_job(2, 1'b0, 0, 0, 1'b0, 1'b0, 32'd0);

    // Abort during LOAD_B, then a clean job.
    partial_load();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort_load_b");
    run_job(2, 1'b1, 0, 0, 1'b1, 1'b0, 32'd0);

    // Abort in the same cycle as an output handshake: no done, valid dropped.
    @(negedge clk);
    start = 1'b1; size = 4'd1; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'd7;
    @(negedge clk);
    in_data = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("abort_out_valid_seen", 32'(out_valid), 32'd1);
    chk("abort_out_value", out_data, 32'd63);
    out_ready = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    chk_idle("abort_output");
    @(negedge clk);
    chk("abort_no_done", {30'd0, done, err}, 32'd0);
    run_job(2, 1'b0, 0, 0, 1'b0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_mult_stream.md
MATRIX_MULT_STREAM -- requirements
Module: matrix_mult_stream

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 10, maximum square matrix dimension.
REQ-002 SHALL have parameter DATA_W, default 32, element width of A and B.
REQ-003 SHALL have parameter ACC_W, default 32, accumulator and result width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  job request, sampled only in IDLE.
REQ-007 SHALL have port size  in  $clog2(MAX_SIZE+1)  runtime dimension N, latched on accepted start.
REQ-008 SHALL have port signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched with size.
REQ-009 SHALL have port abort  in  1  synchronous job cancel.
REQ-010 SHALL have port in_valid / in_ready / in_data  in / out / DATA_W  operand stream: N*N A elements row-major, then N*N B elements row-major.
REQ-011 SHALL have port out_valid / out_ready / out_data  out / in / ACC_W  result stream: N*N C elements row-major.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port done  out  1  one-cycle pulse after the last C element is accepted.
REQ-014 SHALL have port err  out  1  one-cycle pulse when start is rejected.

Function
REQ-015 FSM states SHALL be IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT.
REQ-016 IDLE: start with 1<=size<=MAX_SIZE -> LOAD_A next cycle; start with size 0 or size>MAX_SIZE -> err pulse next cycle, stay IDLE.
REQ-017 in_ready SHALL be 1 only in LOAD_A/LOAD_B; a beat is in_valid&&in_ready; beats outside these states are not consumed.
REQ-018 LOAD_A SHALL store beat k at A[k/N][k%N]; after beat N*N-1 -> LOAD_B; LOAD_B likewise for B, then -> COMPUTE with (i,j)=(0,0).
REQ-019 COMPUTE SHALL perform one MAC per cycle, acc += A[i][k]*B[k][j], k=0..N-1, acc cleared at entry; exactly N cycles, then -> OUTPUT.
REQ-020 Products and sums SHALL be formed at ACC_W bits (sign- or zero-extended per signed_mode); result is modulo 2^ACC_W, no saturation.
REQ-021 OUTPUT: out_valid=1, out_data=acc; out_data and out_valid SHALL remain stable until out_ready.
REQ-022 On out_valid&&out_ready: if (i,j)=(N-1,N-1) -> IDLE with done=1 next cycle; else advance j then i, -> COMPUTE.
REQ-023 start while busy SHALL be ignored (no err, no effect).
REQ-024 abort SHALL return FSM to IDLE next cycle from any state, drop out_valid, no done, no err; abort has priority over all handshakes in the same cycle.
REQ-025 N=1 SHALL work: one A beat, one B beat, one COMPUTE cycle, one output.
REQ-026 Operand storage SHALL be MAX_SIZE*MAX_SIZE per matrix; entries beyond N unused.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, counters 0, acc 0, in_ready 0, out_valid 0, out_data 0, busy 0, done 0, err 0.
REQ-028 Reset mid-job SHALL discard the job; operand storage contents need not be cleared.

Structure
REQ-029 Shared package matrix_pkg SHALL hold the FSM state enum and the default MAX_SIZE/DATA_W/ACC_W constants.
REQ-030 One sub-module mm_mac (registered multiply-accumulate with clear, enable, signed_mode) SHALL be used; control and storage stay in the top.

Verification
REQ-031 N=10, A[i][j]=10i+j+1, B[i][j]=100-10j-i, unsigned, out_ready=1 -> 100 outputs, C[0][0]=5170, done pulses once, busy falls same cycle done rises.
REQ-032 N=1, signed_mode=1, A=-2, B=3 -> out_data=32'hFFFFFFFA after exactly 1 COMPUTE cycle.
REQ-033 start with size=0, then size=11 -> err pulse each, busy stays 0, in_ready stays 0.
REQ-034 N=2, out_ready low 5 cycles on first result -> out_data constant and out_valid high all 5 cycles, no element lost or duplicated.
REQ-035 rst_n low during LOAD_B, then new N=2 job -> all outputs at reset values, second job results correct; repeat with abort instead of reset -> same.
